// File: rtl/tl_rx_credit_return.sv
// tl_rx_credit_return: Rx flow-control credit manager (InitFC, UpdateFC return, overflow detect).
// Optional macro TL_FC_UPDATE_COALESCE_EN: coalesce UpdateFC by pending threshold or timer.
module tl_rx_credit_return #(
    parameter int PH_CAP      = 16,
    parameter int PD_CAP      = 128,
    parameter int NH_CAP      = 16,
    parameter int CH_CAP      = 16,
    parameter int CD_CAP      = 128,
    parameter int UPD_THRESH  = 4,
    parameter int UPD_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        link_active_i,
    input  logic        rx_tlp_valid_i,
    input  logic [1:0]  rx_tlp_type_i,
    input  logic [9:0]  rx_tlp_len_i,
    input  logic        rx_tlp_hasdata_i,
    input  logic        p_hdr_rden_i,
    input  logic        np_hdr_rden_i,
    input  logic        cpl_hdr_rden_i,
    input  logic        p_data_rden_i,
    input  logic        cpl_data_rden_i,
    output logic [11:0] init_ph_o,
    output logic [11:0] init_pd_o,
    output logic [11:0] init_nh_o,
    output logic [11:0] init_ch_o,
    output logic [11:0] init_cd_o,
    output logic        init_en_o,
    input  logic        init_ack_i,
    output logic [11:0] upd_hdr_o,
    output logic [11:0] upd_data_o,
    output logic [1:0]  upd_cls_o,
    output logic        upd_valid_o,
    input  logic        upd_ack_i,
    output logic        ovf_o
);
    localparam logic [11:0] PH_C = 12'(PH_CAP);
    localparam logic [11:0] PD_C = 12'(PD_CAP);
    localparam logic [11:0] NH_C = 12'(NH_CAP);
    localparam logic [11:0] CH_C = 12'(CH_CAP);
    localparam logic [11:0] CD_C = 12'(CD_CAP);

    if (UPD_THRESH < 1 || UPD_TIMEOUT < 1) begin : g_bad_cfg
        $error("tl_rx_credit_return: UPD_THRESH and UPD_TIMEOUT must be positive");
    end

    typedef enum logic [1:0] {LINK_DOWN, INIT, ACTIVE, UPD} state_t;
    state_t state, state_nx;

    logic [11:0] pend_ph, pend_pd, pend_nh, pend_ch, pend_cd;
    logic [11:0] out_ph, out_pd, out_nh, out_ch, out_cd;
    logic        run, ack_now, tlp_p, tlp_n, tlp_c;
    logic [10:0] len_rnd;
    logic [11:0] dcred;
    logic        el_p, el_n, el_c, any_el;

    assign run     = link_active_i && state != LINK_DOWN;
    assign ack_now = state == UPD && upd_ack_i;
    assign tlp_p   = rx_tlp_valid_i && rx_tlp_type_i == 2'd0;
    assign tlp_n   = rx_tlp_valid_i && rx_tlp_type_i == 2'd1;
    assign tlp_c   = rx_tlp_valid_i && rx_tlp_type_i == 2'd2;
    assign len_rnd = {1'b0, rx_tlp_len_i} + 11'd3;
    assign dcred   = !rx_tlp_hasdata_i ? 12'd0 :
                     rx_tlp_len_i == 10'd0 ? 12'd256 : {3'b0, len_rnd[10:2]};

    function automatic logic [11:0] pend_nx(input logic [11:0] p, input logic [11:0] sub,
                                            input logic [1:0] add);
        logic [12:0] s;
        s = {1'b0, p - sub} + {11'b0, add};
        return s[12] ? 12'hFFF : s[11:0];
    endfunction

`ifdef TL_FC_UPDATE_COALESCE_EN
    localparam int TW = $clog2(UPD_TIMEOUT + 1) > 8 ? $clog2(UPD_TIMEOUT + 1) : 8;
    localparam logic [TW-1:0] TMO  = TW'(UPD_TIMEOUT);
    localparam logic [11:0]   TH_H = 12'(UPD_THRESH);
    localparam logic [11:0]   TH_D = 12'(2 * UPD_THRESH);
    logic [TW-1:0] timer;
    logic          tmo, any_pend;

    assign any_pend = |{pend_ph, pend_pd, pend_nh, pend_ch, pend_cd};
    assign tmo      = timer >= TMO;
    assign el_p     = pend_ph >= TH_H || pend_pd >= TH_D || (tmo && |{pend_ph, pend_pd});
    assign el_n     = pend_nh >= TH_H || (tmo && |pend_nh);
    assign el_c     = pend_ch >= TH_H || pend_cd >= TH_D || (tmo && |{pend_ch, pend_cd});

    // Coalescing timer: runs while credits wait in ACTIVE, restarts on every accepted update
    always_ff @(posedge clk) begin
        if (!rst_n || !link_active_i || ack_now)
            timer <= '0;
        else if (state == ACTIVE && any_pend && timer != '1)
            timer <= timer + 1'b1;
    end
`else
    assign el_p = |{pend_ph, pend_pd};
    assign el_n = |pend_nh;
    assign el_c = |{pend_ch, pend_cd};
`endif

    assign any_el = el_p || el_n || el_c;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= LINK_DOWN;
        else
            state <= state_nx;
    end

    // Next state and handshake outputs; link loss overrides everything
    always_comb begin
        state_nx    = state;
        init_en_o   = 1'b0;
        upd_valid_o = 1'b0;
        init_ph_o   = '0;
        init_pd_o   = '0;
        init_nh_o   = '0;
        init_ch_o   = '0;
        init_cd_o   = '0;
        state_nx    = !link_active_i   ? LINK_DOWN :
                      state == LINK_DOWN ? INIT :
                      state == INIT      ? (init_ack_i ? ACTIVE : INIT) :
                      state == ACTIVE    ? (any_el ? UPD : ACTIVE) :
                                           (upd_ack_i ? ACTIVE : UPD);
        init_en_o   = state == INIT;
        upd_valid_o = state == UPD;
        init_ph_o   = init_en_o ? PH_C : 12'd0;
        init_pd_o   = init_en_o ? PD_C : 12'd0;
        init_nh_o   = init_en_o ? NH_C : 12'd0;
        init_ch_o   = init_en_o ? CH_C : 12'd0;
        init_cd_o   = init_en_o ? CD_C : 12'd0;
    end

    // Latch the highest-priority eligible class (CPL > P > NP) when an update is launched
    always_ff @(posedge clk) begin
        if (!rst_n || !link_active_i) begin
            upd_cls_o  <= 2'd0;
            upd_hdr_o  <= '0;
            upd_data_o <= '0;
        end else if (state == ACTIVE && any_el) begin
            upd_cls_o  <= el_c ? 2'd2 : el_p ? 2'd0 : 2'd1;
            upd_hdr_o  <= el_c ? pend_ch : el_p ? pend_ph : pend_nh;
            upd_data_o <= el_c ? pend_cd : el_p ? pend_pd : 12'd0;
        end
    end

    // Pending (freed, not yet returned) and outstanding (held in Rx FIFOs) credit counters
    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            pend_ph <= '0;
            pend_pd <= '0;
            pend_nh <= '0;
            pend_ch <= '0;
            pend_cd <= '0;
            out_ph  <= '0;
            out_pd  <= '0;
            out_nh  <= '0;
            out_ch  <= '0;
            out_cd  <= '0;
        end else begin
            pend_ph <= pend_nx(pend_ph, ack_now && upd_cls_o == 2'd0 ? upd_hdr_o : 12'd0,
                               {1'b0, p_hdr_rden_i});
            pend_pd <= pend_nx(pend_pd, ack_now && upd_cls_o == 2'd0 ? upd_data_o : 12'd0,
                               {p_data_rden_i, 1'b0});
            pend_nh <= pend_nx(pend_nh, ack_now && upd_cls_o == 2'd1 ? upd_hdr_o : 12'd0,
                               {1'b0, np_hdr_rden_i});
            pend_ch <= pend_nx(pend_ch, ack_now && upd_cls_o == 2'd2 ? upd_hdr_o : 12'd0,
                               {1'b0, cpl_hdr_rden_i});
            pend_cd <= pend_nx(pend_cd, ack_now && upd_cls_o == 2'd2 ? upd_data_o : 12'd0,
                               {cpl_data_rden_i, 1'b0});
            out_ph  <= out_ph + {11'b0, tlp_p} - {11'b0, p_hdr_rden_i};
            out_pd  <= out_pd + (tlp_p ? dcred : 12'd0) - {10'b0, p_data_rden_i, 1'b0};
            out_nh  <= out_nh + {11'b0, tlp_n} - {11'b0, np_hdr_rden_i};
            out_ch  <= out_ch + {11'b0, tlp_c} - {11'b0, cpl_hdr_rden_i};
            out_cd  <= out_cd + (tlp_c ? dcred : 12'd0) - {10'b0, cpl_data_rden_i, 1'b0};
        end
    end

    // Sticky overflow: any class holding more than it advertised; only reset clears it
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf_o <= 1'b0;
        else if (out_ph > PH_C || out_pd > PD_C || out_nh > NH_C || out_ch > CH_C || out_cd > CD_C)
            ovf_o <= 1'b1;
    end
endmodule
